// File: rtl/aha_sleep_sequencer_if.sv
// Handshake/status bundle between the platform side (CPU, WIC, debug, software
// gate requests) and the deep-sleep sequencer.
interface aha_sleep_sequencer_if #(
  parameter int NUM_DOMAINS = 8
);
  logic                   SLEEPDEEP;
  logic                   WAKEUP;
  logic                   WIC_EN_ACK;
  logic                   DBG_REQ;
  logic [NUM_DOMAINS-1:0] SW_GATE_EN;
  logic                   WIC_EN_REQ;
  logic                   DBG_ACK;
  logic [NUM_DOMAINS-1:0] GATE_EN;
  logic                   CPU_GATE_EN;
  logic                   SEQ_BUSY;
  logic [2:0]             STATE;

  // Platform side: drives requests, observes the sequencer.
  modport master (
    output SLEEPDEEP, WAKEUP, WIC_EN_ACK, DBG_REQ, SW_GATE_EN,
    input  WIC_EN_REQ, DBG_ACK, GATE_EN, CPU_GATE_EN, SEQ_BUSY, STATE
  );

  // Sequencer side.
  modport slave (
    input  SLEEPDEEP, WAKEUP, WIC_EN_ACK, DBG_REQ, SW_GATE_EN,
    output WIC_EN_REQ, DBG_ACK, GATE_EN, CPU_GATE_EN, SEQ_BUSY, STATE
  );
endinterface

// File: rtl/aha_sleep_sequencer.sv
// Deep-sleep entry/exit sequencer: WIC enable handshake, staggered gating of
// peripheral clock domains followed by the CPU clock, reverse-order ungating
// on wakeup/debug, and a debug power-up acknowledge granted only when awake.
module aha_sleep_sequencer #(
  parameter int NUM_DOMAINS = 8,
  parameter int STEP_CYCLES = 4,
  parameter int WIC_TIMEOUT = 16
) (
  input logic                   CLK,
  input logic                   RESETn,
  aha_sleep_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_WIC_HS = 3'd1,
    ST_GATE   = 3'd2,
    ST_SLEEP  = 3'd3,
    ST_UNGATE = 3'd4
  } state_t;

  localparam int IW = $clog2(NUM_DOMAINS) + 1;
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int TW = (WIC_TIMEOUT > 1) ? $clog2(WIC_TIMEOUT) : 1;

  localparam logic [IW-1:0]          IDX_FULL = IW'(NUM_DOMAINS);
  localparam logic [IW-1:0]          IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]          IDX_ZERO = IW'(0);
  localparam logic [CW-1:0]          CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [TW-1:0]          TMO_LAST = TW'(WIC_TIMEOUT - 1);
  localparam logic [TW-1:0]          TMO_ONE  = TW'(1);
  localparam logic [NUM_DOMAINS-1:0] BIT0     = NUM_DOMAINS'(1);

  state_t                   st_r, st_nxt_s;
  logic [NUM_DOMAINS-1:0]   gate_r, gate_nxt_s;
  logic                     cpu_gate_r, cpu_gate_nxt_s;
  logic                     wic_req_r, wic_req_nxt_s;
  logic                     dbg_ack_r, dbg_ack_nxt_s;
  logic                     busy_r;
  logic                     abort_r, abort_nxt_s;
  logic [IW-1:0]            idx_r, idx_nxt_s;
  logic [CW-1:0]            cnt_r, cnt_nxt_s;
  logic [TW-1:0]            tmo_r, tmo_nxt_s;

  logic                     wake_s;
  logic                     step_s;
  logic [NUM_DOMAINS-1:0]   gate_mask_s;
  logic [NUM_DOMAINS-1:0]   ungate_mask_s;

  assign wake_s        = bus.WAKEUP | bus.DBG_REQ;
  assign step_s        = (cnt_r == CNT_LAST);
  assign gate_mask_s   = BIT0 << idx_r;
  assign ungate_mask_s = BIT0 << (idx_r - IDX_ONE);

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      st_r <= ST_RUN;
    end else begin
      st_r <= st_nxt_s;
    end
  end

  // Next-state decision; wakeup/debug always pre-empt handshake and gating.
  always_comb begin
    st_nxt_s = st_r;
    case (st_r)
      ST_RUN: begin
        if (bus.SLEEPDEEP && !wake_s && !abort_r) st_nxt_s = ST_WIC_HS;
        else                                      st_nxt_s = ST_RUN;
      end
      ST_WIC_HS: begin
        if (wake_s || !bus.SLEEPDEEP) st_nxt_s = ST_RUN;
        else if (bus.WIC_EN_ACK)      st_nxt_s = ST_GATE;
        else if (tmo_r == TMO_LAST)   st_nxt_s = ST_RUN;
        else                          st_nxt_s = ST_WIC_HS;
      end
      ST_GATE: begin
        if (wake_s)                           st_nxt_s = ST_UNGATE;
        else if (step_s && idx_r == IDX_FULL) st_nxt_s = ST_SLEEP;
        else                                  st_nxt_s = ST_GATE;
      end
      ST_SLEEP: begin
        if (wake_s) st_nxt_s = ST_UNGATE;
        else        st_nxt_s = ST_SLEEP;
      end
      ST_UNGATE: begin
        if (idx_r == IDX_ZERO)                   st_nxt_s = ST_RUN;
        else if (step_s && idx_r == IDX_ONE)     st_nxt_s = ST_RUN;
        else                                     st_nxt_s = ST_UNGATE;
      end
      default: st_nxt_s = ST_RUN;
    endcase
  end

  // Next values of outputs, step/timeout counters, domain pointer and abort flag.
  always_comb begin
    gate_nxt_s     = gate_r;
    cpu_gate_nxt_s = cpu_gate_r;
    wic_req_nxt_s  = wic_req_r;
    idx_nxt_s      = idx_r;
    cnt_nxt_s      = cnt_r;
    tmo_nxt_s      = tmo_r;
    abort_nxt_s    = abort_r & bus.SLEEPDEEP;
    dbg_ack_nxt_s  = bus.DBG_REQ & ((st_r == ST_RUN) | dbg_ack_r);
    case (st_r)
      ST_RUN: begin
        gate_nxt_s     = bus.SW_GATE_EN;
        cpu_gate_nxt_s = 1'b0;
        wic_req_nxt_s  = (st_nxt_s == ST_WIC_HS);
        idx_nxt_s      = '0;
        cnt_nxt_s      = '0;
        tmo_nxt_s      = '0;
      end
      ST_WIC_HS: begin
        if (wake_s || !bus.SLEEPDEEP) begin
          wic_req_nxt_s = 1'b0;
        end else if (bus.WIC_EN_ACK) begin
          idx_nxt_s = '0;
          cnt_nxt_s = '0;
        end else if (tmo_r == TMO_LAST) begin
          wic_req_nxt_s = 1'b0;
          abort_nxt_s   = 1'b1;
        end else begin
          tmo_nxt_s = tmo_r + TMO_ONE;
        end
      end
      ST_GATE: begin
        if (wake_s) begin
          cnt_nxt_s = '0;
        end else if (step_s) begin
          cnt_nxt_s = '0;
          if (idx_r == IDX_FULL) begin
            cpu_gate_nxt_s = 1'b1;
          end else begin
            gate_nxt_s = gate_r | gate_mask_s;
            idx_nxt_s  = idx_r + IDX_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SLEEP: begin
        if (wake_s) begin
          cpu_gate_nxt_s = 1'b0;
          cnt_nxt_s      = '0;
          idx_nxt_s      = IDX_FULL;
        end else begin
          cpu_gate_nxt_s = cpu_gate_r;
        end
      end
      ST_UNGATE: begin
        cpu_gate_nxt_s = 1'b0;
        if (idx_r == IDX_ZERO) begin
          wic_req_nxt_s = 1'b0;
        end else if (step_s) begin
          cnt_nxt_s  = '0;
          gate_nxt_s = (gate_r & ~ungate_mask_s) | (bus.SW_GATE_EN & ungate_mask_s);
          idx_nxt_s  = idx_r - IDX_ONE;
          if (idx_r == IDX_ONE) wic_req_nxt_s = 1'b0;
          else                  wic_req_nxt_s = wic_req_r;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        gate_nxt_s     = '0;
        cpu_gate_nxt_s = 1'b0;
        wic_req_nxt_s  = 1'b0;
        idx_nxt_s      = '0;
        cnt_nxt_s      = '0;
        tmo_nxt_s      = '0;
      end
    endcase
  end

  // Output and datapath registers; async reset also releases every gated domain.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      gate_r     <= '0;
      cpu_gate_r <= 1'b0;
      wic_req_r  <= 1'b0;
      dbg_ack_r  <= 1'b0;
      busy_r     <= 1'b0;
      abort_r    <= 1'b0;
      idx_r      <= '0;
      cnt_r      <= '0;
      tmo_r      <= '0;
    end else begin
      gate_r     <= gate_nxt_s;
      cpu_gate_r <= cpu_gate_nxt_s;
      wic_req_r  <= wic_req_nxt_s;
      dbg_ack_r  <= dbg_ack_nxt_s;
      busy_r     <= (st_nxt_s != ST_RUN);
      abort_r    <= abort_nxt_s;
      idx_r      <= idx_nxt_s;
      cnt_r      <= cnt_nxt_s;
      tmo_r      <= tmo_nxt_s;
    end
  end

  assign bus.GATE_EN     = gate_r;
  assign bus.CPU_GATE_EN = cpu_gate_r;
  assign bus.WIC_EN_REQ  = wic_req_r;
  assign bus.DBG_ACK     = dbg_ack_r;
  assign bus.SEQ_BUSY    = busy_r;
  assign bus.STATE       = st_r;

endmodule

// File: tb/tb_aha_sleep_sequencer.sv
// Scoreboard bench for aha_sleep_sequencer: a time-based reference model
// predicts every cycle's outputs into a queue, a monitor compares them.
module tb_aha_sleep_sequencer;
  localparam int N    = 8;
  localparam int STEP = 4;
  localparam int TMO  = 16;

  localparam int S_RUN = 0, S_WIC = 1, S_GATE = 2, S_SLEEP = 3, S_UNGATE = 4;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;

  aha_sleep_sequencer_if #(.NUM_DOMAINS(N)) bus ();

  aha_sleep_sequencer #(
    .NUM_DOMAINS(N), .STEP_CYCLES(STEP), .WIC_TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]   state;
    logic         busy;
    logic         cpu;
    logic         req;
    logic         ack;
    logic [N-1:0] gate;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // reference model state: phase + cycles elapsed in that phase
  int           m_state, m_since, m_n;
  bit           m_abort, m_req, m_cpu, m_dbg;
  logic [N-1:0] m_gate;

  function automatic void model_reset();
    m_state = S_RUN; m_since = 0; m_n = 0;
    m_abort = 0; m_req = 0; m_cpu = 0; m_dbg = 0; m_gate = '0;
  endfunction

  function automatic void model_step();
    bit sd, wk, ak, dq, abort_old;
    logic [N-1:0] sw;
    int nxt, q;
    sd = bus.SLEEPDEEP; wk = bus.WAKEUP; ak = bus.WIC_EN_ACK; dq = bus.DBG_REQ;
    sw = bus.SW_GATE_EN;
    abort_old = m_abort;
    if (!sd) m_abort = 0;
    m_dbg = dq && (m_state == S_RUN || m_dbg);
    nxt = m_state;
    case (m_state)
      S_RUN: begin
        m_gate = sw; m_cpu = 0;
        if (sd && !wk && !dq && !abort_old) begin nxt = S_WIC; m_since = 0; m_req = 1; end
        else m_req = 0;
      end
      S_WIC: begin
        m_since++;
        if (wk || dq || !sd) begin nxt = S_RUN; m_req = 0; end
        else if (ak) begin nxt = S_GATE; m_since = 0; end
        else if (m_since == TMO) begin nxt = S_RUN; m_req = 0; m_abort = 1; end
      end
      S_GATE: begin
        m_since++;
        if (wk || dq) begin
          m_n = (m_since - 1) / STEP;
          if (m_n > N) m_n = N;
          nxt = S_UNGATE; m_since = 0;
        end else if (m_since % STEP == 0) begin
          q = m_since / STEP;
          if (q <= N) m_gate[q-1] = 1'b1;
          else begin m_cpu = 1; nxt = S_SLEEP; end
        end
      end
      S_SLEEP: begin
        if (wk || dq) begin nxt = S_UNGATE; m_n = N; m_cpu = 0; m_since = 0; end
      end
      S_UNGATE: begin
        m_since++;
        if (m_n == 0) begin nxt = S_RUN; m_req = 0; end
        else if (m_since % STEP == 0) begin
          q = m_since / STEP;
          m_gate[m_n-q] = sw[m_n-q];
          if (q == m_n) begin nxt = S_RUN; m_req = 0; end
        end
      end
      default: nxt = S_RUN;
    endcase
    m_state = nxt;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.state = 3'(m_state);
    o.busy  = (m_state != S_RUN);
    o.cpu   = m_cpu;
    o.req   = m_req;
    o.ack   = m_dbg;
    o.gate  = m_gate;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state = bus.STATE; o.busy = bus.SEQ_BUSY; o.cpu = bus.CPU_GATE_EN;
    o.req = bus.WIC_EN_REQ; o.ack = bus.DBG_ACK; o.gate = bus.GATE_EN;
    return o;
  endfunction

  // monitor: pops one prediction per cycle and compares it to the DUT
  initial begin : monitor
    obs_t e, g;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = sample();
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs cyc=%0d got state=%0d busy=%0b cpu=%0b req=%0b ack=%0b gate=%h | expected state=%0d busy=%0b cpu=%0b req=%0b ack=%0b gate=%h",
                   cyc, g.state, g.busy, g.cpu, g.req, g.ack, g.gate,
                   e.state, e.busy, e.cpu, e.req, e.ack, e.gate);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    cyc++;
    if (!RESETn) model_reset();
    else         model_step();
    exp_q.push_back(model_obs());
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input bit sd, input bit wk, input bit ak, input bit dq,
                       input logic [N-1:0] sw);
    bus.SLEEPDEEP = sd; bus.WAKEUP = wk; bus.WIC_EN_ACK = ak;
    bus.DBG_REQ = dq; bus.SW_GATE_EN = sw;
  endtask

  // full sleep entry then wake (WAKEUP pulse or held DBG_REQ)
  task automatic full_cycle(input logic [N-1:0] sw, input int ack_dly, input bit use_dbg);
    drive(1'b1, 1'b0, 1'b0, 1'b0, sw);
    ticks(ack_dly);
    bus.WIC_EN_ACK = 1'b1; tick(); bus.WIC_EN_ACK = 1'b0;
    ticks((N + 1) * STEP + 3);
    if (use_dbg) bus.DBG_REQ = 1'b1; else bus.WAKEUP = 1'b1;
    tick();
    bus.WAKEUP = 1'b0; bus.SLEEPDEEP = 1'b0;
    for (int i = 0; i < N * STEP + 3; i++) begin
      if (sw != '0) bus.SW_GATE_EN = N'($urandom);
      tick();
    end
    bus.DBG_REQ = 1'b0;
    ticks(3);
  endtask

  // wake (or debug) after a given number of cycles in GATE
  task automatic abort_gate(input logic [N-1:0] sw, input int gate_cycles, input bit use_dbg);
    drive(1'b1, 1'b0, 1'b0, 1'b0, sw);
    ticks(2);
    bus.WIC_EN_ACK = 1'b1; tick(); bus.WIC_EN_ACK = 1'b0;
    ticks(gate_cycles);
    if (use_dbg) bus.DBG_REQ = 1'b1; else bus.WAKEUP = 1'b1;
    tick();
    drive(1'b0, 1'b0, 1'b0, use_dbg, sw);
    ticks(N * STEP + 4);
    bus.DBG_REQ = 1'b0;
    ticks(2);
  endtask

  // asynchronous reset between clock edges, checked before the next edge
  task automatic async_reset_check();
    #2 RESETn = 1'b0;
    #1;
    tests++;
    if (bus.GATE_EN !== '0 || bus.CPU_GATE_EN !== 1'b0 || bus.WIC_EN_REQ !== 1'b0 ||
        bus.DBG_ACK !== 1'b0 || bus.STATE !== 3'd0 || bus.SEQ_BUSY !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got gate=%h cpu=%0b req=%0b ack=%0b state=%0d busy=%0b, expected all 0",
               bus.GATE_EN, bus.CPU_GATE_EN, bus.WIC_EN_REQ, bus.DBG_ACK, bus.STATE, bus.SEQ_BUSY);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    ticks(2);
    RESETn = 1'b1;
    ticks(2);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    RESETn = 1'b0;
    ticks(3);
    RESETn = 1'b1;
    ticks(4);

    // full cycle with SW gates clear, then with random SW gates
    full_cycle(8'h00, 3, 1'b0);
    full_cycle(8'h5a, 1, 1'b0);
    full_cycle(N'($urandom), $urandom_range(1, 6), 1'b1);

    // WIC timeout, no retry until SLEEPDEEP toggles
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h3c);
    ticks(TMO + 10);
    bus.SLEEPDEEP = 1'b0; tick();
    bus.SLEEPDEEP = 1'b1; ticks(4);
    bus.SLEEPDEEP = 1'b0; ticks(3);

    // abort mid-gate: exact 0x07 point, SW=0x05, random points, abort at idx 0
    abort_gate(8'h00, 3 * STEP, 1'b0);
    abort_gate(8'h05, 3 * STEP, 1'b0);
    abort_gate(8'h00, 1, 1'b0);
    abort_gate(8'h00, N * STEP + 1, 1'b1);
    for (int i = 0; i < 4; i++)
      abort_gate(N'($urandom), $urandom_range(0, (N + 1) * STEP - 1), 1'($urandom_range(0, 1)));

    // debug held with SLEEPDEEP: never leaves RUN; release then enters handshake
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h81);
    ticks(6);
    bus.DBG_REQ = 1'b0; ticks(3);
    bus.SLEEPDEEP = 1'b0; ticks(2);

    // WAKEUP and WIC_EN_ACK together in the handshake
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    ticks(2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h11);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
    ticks(3);

    // reset while asleep with every domain gated
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    ticks(2);
    bus.WIC_EN_ACK = 1'b1; tick(); bus.WIC_EN_ACK = 1'b0;
    ticks((N + 1) * STEP + 2);
    async_reset_check();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bus.SLEEPDEEP  = ($urandom_range(0, 15) != 0);
      bus.WAKEUP     = ($urandom_range(0, 45) == 0);
      bus.WIC_EN_ACK = ($urandom_range(0, 4) == 0);
      if (bus.DBG_REQ) bus.DBG_REQ = ($urandom_range(0, 7) != 0);
      else             bus.DBG_REQ = ($urandom_range(0, 90) == 0);
      if ($urandom_range(0, 7) == 0) bus.SW_GATE_EN = N'($urandom);
      tick();
    end

    // reset at an arbitrary point of random traffic
    async_reset_check();

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    ticks(2);
    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
